// File: rtl/dds_seq_ctrl.sv
// rtl/dds_seq_ctrl.sv - DDS segment sequencer (optional finite loop count via DDS_SEQ_LOOPCNT_EN)
module dds_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 24
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [2:0]       wr_form,
    input  logic [31:0]      wr_inc,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW-1:0]    last_seg,
`ifdef DDS_SEQ_LOOPCNT_EN
    input  logic [7:0]       loop_cnt,
`endif
    output logic [2:0]       form,
    output logic [31:0]      inc,
    output logic             phase_clr,
    output logic [AW-1:0]    seg_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         tbl_form [DEPTH];
    logic [31:0]        tbl_inc  [DEPTH];
    logic [DUR_W-1:0]   tbl_dur  [DEPTH];

    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      last_q, last_d;
    logic               loop_q, loop_d;
    logic [2:0]         form_d;
    logic [31:0]        inc_d;
    logic               clr_d, busy_d, done_d;
    logic [AW-1:0]      idx_d;
    logic               ld_en;
    logic [AW-1:0]      ld_addr;
    logic [DUR_W-1:0]   ld_dur;
    logic               wrap_ok;

`ifdef DDS_SEQ_LOOPCNT_EN
    logic [7:0]         pass_q, pass_d;
    assign wrap_ok = loop_q && (pass_q != 8'd0);
`else
    assign wrap_ok = loop_q;
`endif

    assign ld_dur = tbl_dur[ld_addr];

    // Segment table: host writes land at the edge, so a same-edge load sees old contents
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_form[i] <= 3'd0;
                tbl_inc[i]  <= 32'd0;
                tbl_dur[i]  <= '0;
            end
        end else if (wr_en) begin
            tbl_form[wr_addr] <= wr_form;
            tbl_inc[wr_addr]  <= wr_inc;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            form      <= 3'd0;
            inc       <= 32'd0;
            phase_clr <= 1'b0;
            seg_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DDS_SEQ_LOOPCNT_EN
            pass_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            loop_q    <= loop_d;
            form      <= form_d;
            inc       <= inc_d;
            phase_clr <= clr_d;
            seg_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef DDS_SEQ_LOOPCNT_EN
            pass_q    <= pass_d;
`endif
        end
    end

    // Next state and next output values; a segment load is shared by start, advance and wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        loop_d  = loop_q;
        form_d  = form;
        inc_d   = inc;
        clr_d   = 1'b0;
        idx_d   = seg_idx;
        busy_d  = busy;
        done_d  = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
`ifdef DDS_SEQ_LOOPCNT_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    state_d = RUN;
                    last_d  = last_seg;
                    loop_d  = loop_en;
`ifdef DDS_SEQ_LOOPCNT_EN
                    pass_d  = loop_cnt;
`endif
                    ld_en   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    inc_d   = 32'd0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (seg_idx != last_q) begin
                    ld_en   = 1'b1;
                    ld_addr = seg_idx + 1'b1;
                end else if (wrap_ok) begin
                    ld_en   = 1'b1;
`ifdef DDS_SEQ_LOOPCNT_EN
                    pass_d  = pass_q - 8'd1;
`endif
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    inc_d   = 32'd0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ld_en) begin
            form_d = tbl_form[ld_addr];
            inc_d  = tbl_inc[ld_addr];
            cnt_d  = (ld_dur == '0) ? '0 : ld_dur - 1'b1;
            idx_d  = ld_addr;
            clr_d  = 1'b1;
            busy_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// tb/tb_dds_seq_ctrl.sv - self-checking bench for dds_seq_ctrl
module tb_dds_seq_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DUR_W = 24;
`ifdef DDS_SEQ_LOOPCNT_EN
    localparam bit LOOPCNT = 1'b1;
`else
    localparam bit LOOPCNT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [2:0]       wr_form = '0;
    logic [31:0]      wr_inc = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [AW-1:0]    last_seg = '0;
    logic [7:0]       loop_cnt = 8'd0;
    logic [2:0]       form;
    logic [31:0]      inc;
    logic             phase_clr;
    logic [AW-1:0]    seg_idx;
    logic             busy;
    logic             done;

    dds_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DUR_W(DUR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_form(wr_form), .wr_inc(wr_inc), .wr_dur(wr_dur),
        .start(start), .stop(stop), .loop_en(loop_en), .last_seg(last_seg),
`ifdef DDS_SEQ_LOOPCNT_EN
        .loop_cnt(loop_cnt),
`endif
        .form(form), .inc(inc), .phase_clr(phase_clr), .seg_idx(seg_idx),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a table copy plus "clocks left in this segment" bookkeeping
    logic [2:0]       m_form [DEPTH];
    logic [31:0]      m_inc  [DEPTH];
    logic [DUR_W-1:0] m_dur  [DEPTH];
    logic [2:0]       e_form = '0;
    logic [31:0]      e_inc = '0;
    logic             e_clr = 1'b0;
    int               e_idx = 0;
    logic             e_busy = 1'b0;
    logic             e_done = 1'b0;
    bit               m_run = 1'b0;
    int               m_rem = 0;
    int               m_last = 0;
    bit               m_loop = 1'b0;
    int               m_left = 0;

    task automatic m_load(input int i);
        e_idx  = i % DEPTH;
        e_form = m_form[e_idx];
        e_inc  = m_inc[e_idx];
        m_rem  = (m_dur[e_idx] == '0) ? 1 : int'(m_dur[e_idx]);
        e_clr  = 1'b1;
        e_busy = 1'b1;
        m_run  = 1'b1;
    endtask

    always @(posedge CLK or posedge RESET) begin : model
        bit was_done;
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_form[i] = '0; m_inc[i] = '0; m_dur[i] = '0;
            end
            e_form = '0; e_inc = '0; e_clr = 1'b0; e_idx = 0; e_busy = 1'b0; e_done = 1'b0;
            m_run = 1'b0;
        end else begin
            was_done = e_done;
            e_clr  = 1'b0;
            e_done = 1'b0;
            if (m_run) begin
                if (stop) begin
                    m_run = 1'b0; e_inc = '0; e_busy = 1'b0; e_idx = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (e_idx != m_last) m_load(e_idx + 1);
                        else if (m_loop && (!LOOPCNT || m_left > 0)) begin
                            m_left--;
                            m_load(0);
                        end else begin
                            m_run = 1'b0; e_done = 1'b1; e_busy = 1'b0; e_inc = '0;
                        end
                    end
                end
            end else if (!was_done && start && !stop) begin
                m_last = int'(last_seg);
                m_loop = loop_en;
                m_left = int'(loop_cnt);
                m_load(0);
            end
            if (wr_en) begin
                m_form[wr_addr] = wr_form; m_inc[wr_addr] = wr_inc; m_dur[wr_addr] = wr_dur;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        chk("form", 32'(form), 32'(e_form));
        chk("inc", inc, e_inc);
        chk("phase_clr", 32'(phase_clr), 32'(e_clr));
        chk("seg_idx", 32'(seg_idx), 32'(e_idx));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [2:0] f, input logic [31:0] i, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_form = f; wr_inc = i; wr_dur = DUR_W'(d);
        step();
        wr_en = 1'b0;
    endtask

    logic [2:0] exp_idx [10];
    int ndone, dcyc;

    initial begin
        exp_idx = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inc", inc, 32'd0);
        RESET = 1'b0;
        step();

        // Two-segment one-shot
        wr(0, 3'b000, 32'h0100_0000, 4);
        wr(1, 3'b010, 32'h0200_0000, 2);
        last_seg = 3'd1; loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("t1_c1_clr", 32'(phase_clr), 32'd1);
        chk("t1_c1_inc", inc, 32'h0100_0000);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        repeat (4) step();
        chk("t1_c5_clr", 32'(phase_clr), 32'd1);
        chk("t1_c5_form", 32'(form), 32'd2);
        chk("t1_c5_inc", inc, 32'h0200_0000);
        repeat (2) step();
        chk("t1_c7_done", 32'(done), 32'd1);
        chk("t1_c7_inc", inc, 32'd0);
        chk("t1_c7_form", 32'(form), 32'd2);
        step();
        chk("t1_c8_done", 32'(done), 32'd0);

        // Looping sequence, aborted at cycle 10
        loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("t2_idx", 32'(seg_idx), 32'(exp_idx[c-1]));
            if (c == 7) chk("t2_wrap_clr", 32'(phase_clr), 32'd1);
            if (c < 10) step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("t2_stop_busy", 32'(busy), 32'd0);
        chk("t2_stop_idx", 32'(seg_idx), 32'd0);
        chk("t2_stop_inc", inc, 32'd0);
        step();
        chk("t2_no_done", 32'(done), 32'd0);
        loop_en = 1'b0;

        // Zero duration behaves as one clock
        wr(0, 3'b001, 32'h10, 0);
        last_seg = 3'd0;
        start = 1'b1; step(); start = 1'b0;
        chk("t3_c1_busy", 32'(busy), 32'd1);
        chk("t3_c1_form", 32'(form), 32'd1);
        step();
        chk("t3_c2_done", 32'(done), 32'd1);
        step();

        // start+stop together, restart attempt mid-run, same-edge write/load
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", 32'(busy), 32'd0);
        wr(0, 3'b000, 32'h0100_0000, 4);
        last_seg = 3'd1;
        start = 1'b1; step(); start = 1'b0;
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("t4_norestart_clr", 32'(phase_clr), 32'd0);
        chk("t4_norestart_busy", 32'(busy), 32'd1);
        step();
        wr_en = 1'b1; wr_addr = 3'd1; wr_form = 3'b100; wr_inc = 32'h0300_0000; wr_dur = 24'd2;
        step(); wr_en = 1'b0;
        chk("t4_old_inc", inc, 32'h0200_0000);
        chk("t4_old_form", 32'(form), 32'd2);
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        chk("t4_new_inc", inc, 32'h0300_0000);
        chk("t4_new_form", 32'(form), 32'd4);
        repeat (3) step();

        // Asynchronous reset mid-segment
        wr(0, 3'b011, 32'h5, 100);
        last_seg = 3'd0;
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        #2 RESET = 1'b1;
        #1;
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_form", 32'(form), 32'd0);
        chk("t5_async_inc", inc, 32'd0);
        step();
        RESET = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("t5_replay_clr", 32'(phase_clr), 32'd1);
        chk("t5_replay_inc", inc, 32'd0);
        step();
        chk("t5_replay_done", 32'(done), 32'd1);
        step();

`ifdef DDS_SEQ_LOOPCNT_EN
        // Finite loop count: three passes of a six-clock sequence
        wr(0, 3'b000, 32'h1, 4);
        wr(1, 3'b010, 32'h2, 2);
        last_seg = 3'd1; loop_en = 1'b1; loop_cnt = 8'd2;
        start = 1'b1; step(); start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin ndone++; dcyc = c; end
            step();
        end
        chk("t6_ndone", 32'(ndone), 32'd1);
        chk("t6_done_cycle", 32'(dcyc), 32'd19);
        loop_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dds_seq_ctrl.md
# dds_seq_ctrl

Segment sequencer for the DDS waveform path. Holds a small programmable table of segments (waveform form code, 32-bit phase increment, duration in clocks) and, once started, drives the phase accumulator's increment and the waveform shaper's `form` select through the table in order. It also pulses a phase-clear at every segment boundary, optionally loops the sequence, and reports busy/done status to the host register block.

## Interface
Parameters:
- `DEPTH`, 8: number of table segments; power of two.
- `AW`, 3: segment address width, log2(`DEPTH`).
- `DUR_W`, 24: duration field width.

Ports:
- `CLK`  in  1  clock.
- `RESET`  in  1  reset RESET, asynchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  segment index to write.
- `wr_form`  in  3  form code (000 saw, 001 reverse saw, 010 triangle, 011 meander, 100 pulse).
- `wr_inc`  in  32  phase increment.
- `wr_dur`  in  DUR_W  segment length in clocks.
- `start`  in  1  start-sequence pulse.
- `stop`  in  1  abort pulse.
- `loop_en`  in  1  repeat the sequence after the last segment.
- `last_seg`  in  AW  index of the final segment.
- `form`  out  3  form select to the shaper.
- `inc`  out  32  phase increment to the accumulator.
- `phase_clr`  out  1  one-cycle accumulator clear.
- `seg_idx`  out  AW  active segment.
- `busy`  out  1  sequence running.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on `start`. At that edge the block loads segment 0 into `form` and `inc`, sets `seg_idx`=0, `busy`=1, asserts `phase_clr`, and loads the down-counter with `dur`-1.
- `loop_en` and `last_seg` are sampled at start. Changing them during RUN has no effect.
- In RUN the counter decrements each clock. At an edge where the counter is 0:
  - If `seg_idx` != latched last, the block advances to `seg_idx`+1, loads that segment, and pulses `phase_clr`.
  - If `seg_idx` == latched last and loop is on, it wraps to segment 0 (same load and `phase_clr`).
  - Otherwise it goes to DONE.
- DONE lasts one cycle: `done`=1, `busy`=0, `inc`=0, `form` holds its last value. Then it returns to IDLE.
- `stop` in RUN: next edge goes to IDLE with `inc`=0, `busy`=0, `seg_idx`=0 and no `done` pulse.
- `stop` and `start` asserted together: `stop` wins and the state stays or becomes IDLE.
- `start` while in RUN or DONE is ignored.
- `dur`=0 is treated as 1 clock.
- Table writes are accepted in every state. A write to the active segment affects only later loads of that segment. A write and a load of the same address in the same cycle loads the old contents.
- A latched last index ≥ `DEPTH` cannot occur (width-limited). The index wraps modulo `DEPTH`.
- In IDLE, `inc`=0 so the accumulator freezes.

## Timing
- Reset values: `form`=000, `inc`=0, `phase_clr`=0, `seg_idx`=0, `busy`=0, `done`=0, state IDLE. All table entries are cleared (form 000, inc 0, dur 0).
- Latency: `start` sampled at edge k gives new outputs valid after edge k.
- Each segment holds exactly max(`dur`,1) clocks. No gap cycles occur between segments.
- `phase_clr` is high for exactly the first cycle of each segment.
- `done` rises on the cycle after the last segment's final clock.
- All outputs are registered. The table read is combinational from registers.
- RESET asserted mid-RUN drops all outputs to their reset values immediately (asynchronously).

## Configuration
- `DDS_SEQ_LOOPCNT_EN` defined:
  - Adds input `loop_cnt[7:0]`, sampled at start.
  - With `loop_en`=1 the sequence runs `loop_cnt`+1 passes, then goes to DONE.
  - An internal pass counter decrements on each wrap.
- Not defined:
  - No `loop_cnt` port.
  - `loop_en`=1 repeats indefinitely until `stop`.

## Test plan
- Load seg0 {form 000, inc 0x0100_0000, dur 4} and seg1 {form 010, inc 0x0200_0000, dur 2}; `last_seg`=1, `loop_en`=0; pulse `start`.
  - Expect seg0 outputs for 4 clocks, then seg1 for 2 clocks.
  - Expect `phase_clr` on cycles 1 and 5, and `done` on cycle 7.
  - Expect `inc`=0 afterwards.
- Same table with `loop_en`=1 (macro undefined): `seg_idx` repeats 0,0,0,0,1,1,0… with no gap cycles. Pulse `stop` at cycle 10 → `busy`=0 next cycle and no `done`.
- Segment 0 with `dur`=0 and `last_seg`=0 → RUN lasts exactly 1 clock, then `done`.
- Assert `start` and `stop` in the same cycle from IDLE → stays IDLE with `busy`=0. Pulse `start` again during RUN → the sequence is not restarted.
- Assert RESET mid-segment with `dur`=100 → all outputs reset immediately. After release, `start` replays from segment 0 with the cleared table (inc 0, dur 1).
- With `DDS_SEQ_LOOPCNT_EN`, `loop_cnt`=2, `loop_en`=1, 2-segment table → exactly 3 passes, then a single `done` pulse.
